// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and default sizes for the uart tx arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    SEND = 2'b10,
    HOLD = 2'b11
  } state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_BITS = 10;
  localparam int TO_W = 16;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request after ptr with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          any
);
  logic [GW-1:0] j;
  // scan from farthest to nearest so the nearest set request after ptr wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = GW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx; UART_ARB_HOLD_TIMEOUT_EN breaks idle locks
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int BITS = DEF_BITS,
  parameter int GID_W = $clog2(NREQ),
  parameter int HOLD_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BITS-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ack,
  output logic [BITS-1:0]      tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ack,
  input  logic                 tx_ready,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 timeout_err
);
  state_t state;
  logic [GID_W-1:0] ptr, pick;
  logic any, last_q, started, to_hit, unused_ok;
  // uart_tx only samples valid while idle, so ready never gates our valid
  assign unused_ok = tx_ready ^ (HOLD_TIMEOUT == 0);
  rr_pick #(.N(NREQ), .GW(GID_W)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .idx(pick),
    .any(any)
  );
  assign req_ack = (state == LOAD && req_valid[grant_id]) ? (NREQ'(1) << grant_id) : '0;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  assign to_hit = (cnt == TO_W'(HOLD_TIMEOUT - 1));
  // count idle HOLD cycles and flag the cycle the lock is broken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state == HOLD) ? cnt + 1'b1 : '0;
      timeout_err <= state == HOLD && !req_valid[grant_id] && to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // arbitration, word latching and packet lock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tx_data <= '0;
      tx_data_valid <= 1'b0;
      grant_id <= '0;
      busy <= 1'b0;
      ptr <= GID_W'(NREQ - 1);
      last_q <= 1'b0;
      started <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          grant_id <= pick;
          busy <= 1'b1;
          started <= 1'b0;
          state <= LOAD;
        end
        LOAD: if (req_valid[grant_id]) begin
          tx_data <= req_data[grant_id*BITS +: BITS];
          last_q <= req_last[grant_id];
          started <= 1'b1;
          tx_data_valid <= 1'b1;
          state <= SEND;
        end else begin
          state <= started ? HOLD : IDLE;
          busy <= started;
        end
        SEND: if (tx_data_ack) begin
          tx_data_valid <= 1'b0;
          state <= last_q ? IDLE : HOLD;
          busy <= !last_q;
          if (last_q) ptr <= grant_id;
        end
        HOLD: begin
          state <= req_valid[grant_id] ? LOAD : to_hit ? IDLE : HOLD;
          if (!req_valid[grant_id] && to_hit) begin
            busy <= 1'b0;
            ptr <= grant_id;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench with a small uart_tx responder model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int B = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ack;
  logic [N*B-1:0] req_data = '0;
  logic [B-1:0] tx_data;
  logic tx_data_valid, tx_data_ack, tx_ready, busy, timeout_err;
  logic [1:0] grant_id;
  int n_cmp = 0, n_bad = 0, frame;
  logic [B-1:0] acc_data[$];
  int ack_order[$];

  uart_tx_arbiter #(.NREQ(N), .BITS(B), .HOLD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_data_ack(tx_data_ack), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // uart_tx model: accept when valid and ready, ack next cycle, busy for a short frame
  always @(posedge clk) begin
    if (!rst_n) begin
      tx_ready <= 1'b1;
      tx_data_ack <= 1'b0;
      frame <= 0;
    end else begin
      tx_data_ack <= 1'b0;
      if (frame > 0) begin
        frame <= frame - 1;
        if (frame == 1) tx_ready <= 1'b1;
      end else if (tx_data_valid && tx_ready) begin
        acc_data.push_back(tx_data);
        tx_ready <= 1'b0;
        tx_data_ack <= 1'b1;
        frame <= 6;
      end
    end
  end

  // log which requester got each ack
  always @(posedge clk) begin
    if (rst_n) for (int i = 0; i < N; i++) if (req_ack[i]) ack_order.push_back(i);
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic set_word(input int i, input logic [B-1:0] d, input logic l);
    req_data[i*B +: B] = d;
    req_last[i] = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_data.delete();
    ack_order.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && tx_ready) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_idle timeout busy=%0b tx_ready=%0b", busy, tx_ready);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b exp 0", tx_data_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_gid got %0d exp 0", grant_id); end
    n_cmp++; if (req_ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack got %b exp 0000", req_ack); end
    n_cmp++; if (tx_data !== 10'h0) begin n_bad++; $display("FAIL reset_data got %h exp 000", tx_data); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_terr got %0b exp 0", timeout_err); end
  endtask

  task automatic test_single();
    int k;
    do_reset();
    set_word(0, 10'h155, 1'b1);
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++; if (req_ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack got %b exp 0001", req_ack); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %0b exp 1", busy); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got %0b exp 0", tx_data_valid); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_cmp++; if (tx_data_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0b exp 1", tx_data_valid); end
    n_cmp++; if (tx_data !== 10'h155) begin n_bad++; $display("FAIL single_data got %h exp 155", tx_data); end
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!tx_data_valid) break;
    end
    n_cmp++; if (k !== 1) begin n_bad++; $display("FAIL single_drop_cycle got %0d exp 1", k); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %0b exp 0", busy); end
    n_cmp++; if (acc_data.size() != 1 || acc_data[0] !== 10'h155) begin n_bad++; $display("FAIL single_wire got %0d words exp 1 of 155", acc_data.size()); end
    wait_idle();
  endtask

  task automatic test_fairness();
    int cnt[N];
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, B'(10'h100 + i), 1'b1);
    req_valid = 4'hF;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ack_order.size() >= 8) break;
    end
    req_valid = '0;
    wait_idle();
    n_cmp++;
    if (ack_order.size() != 8 || acc_data.size() != 8) begin
      n_bad++; $display("FAIL fair_count got %0d acks %0d words exp 8", ack_order.size(), acc_data.size());
    end else begin
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < 8; k++) begin
        cnt[ack_order[k]]++;
        n_cmp++; if (ack_order[k] != k % 4) begin n_bad++; $display("FAIL fair_order[%0d] got %0d exp %0d", k, ack_order[k], k % 4); end
        n_cmp++; if (acc_data[k] !== B'(10'h100 + k % 4)) begin n_bad++; $display("FAIL fair_data[%0d] got %h exp %h", k, acc_data[k], 10'h100 + k % 4); end
      end
      for (int i = 0; i < N; i++) begin
        n_cmp++; if (cnt[i] != 2) begin n_bad++; $display("FAIL fair_acks_req%0d got %0d exp 2", i, cnt[i]); end
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [N-1:0] a;
    int w = 0, viol = 0;
    logic done = 1'b0;
    logic [B-1:0] exp_w[4] = '{10'h2A1, 10'h2A2, 10'h2A3, 10'h3C2};
    do_reset();
    set_word(2, 10'h3C2, 1'b1);
    set_word(1, 10'h2A1, 1'b0);
    req_valid = 4'b0110;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      a = req_ack;
      if (w < 3 && grant_id == 2'd2) viol++;
      @(posedge clk); #1;
      if (a[1]) begin
        w++;
        if (w == 1) set_word(1, 10'h2A2, 1'b0);
        else if (w == 2) set_word(1, 10'h2A3, 1'b1);
        else req_valid[1] = 1'b0;
      end
      if (a[2]) begin
        req_valid[2] = 1'b0;
        done = 1'b1;
      end
    end
    wait_idle();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL lock_viol got %0d exp 0", viol); end
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL lock_final_gid got %0d exp 2", grant_id); end
    n_cmp++;
    if (acc_data.size() != 4 || ack_order.size() != 4) begin
      n_bad++; $display("FAIL lock_count got %0d words %0d acks exp 4", acc_data.size(), ack_order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (acc_data[k] !== exp_w[k]) begin n_bad++; $display("FAIL lock_data[%0d] got %h exp %h", k, acc_data[k], exp_w[k]); end
        n_cmp++; if (ack_order[k] != (k < 3 ? 1 : 2)) begin n_bad++; $display("FAIL lock_order[%0d] got %0d exp %0d", k, ack_order[k], k < 3 ? 1 : 2); end
      end
    end
  endtask

  task automatic test_retraction();
    do_reset();
    set_word(3, 10'h0F3, 1'b1);
    set_word(0, 10'h0A0, 1'b1);
    req_valid = 4'b1000;
    @(negedge clk);
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL retr_gid got %0d exp 3", grant_id); end
    req_valid = '0;
    #1;
    n_cmp++; if (req_ack !== 4'b0) begin n_bad++; $display("FAIL retr_ack got %b exp 0000", req_ack); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL retr_busy got %0b exp 0", busy); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL retr_valid got %0b exp 0", tx_data_valid); end
    req_valid = 4'b1001;
    @(negedge clk);
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL retr_regrant got %0d exp 0", grant_id); end
    n_cmp++; if (req_ack !== 4'b0001) begin n_bad++; $display("FAIL retr_reack got %b exp 0001", req_ack); end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    n_cmp++; if (ack_order.size() != 1 || acc_data.size() != 1 || acc_data[0] !== 10'h0A0) begin n_bad++; $display("FAIL retr_wire got %0d acks %0d words exp 1 of 0A0", ack_order.size(), acc_data.size()); end
  endtask

  task automatic test_reset_mid_send();
    int c;
    do_reset();
    set_word(0, 10'h011, 1'b1);
    req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    set_word(2, 10'h2B2, 1'b1);
    req_valid = 4'b0100;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_data_valid) break;
    end
    n_cmp++; if (c == 20) begin n_bad++; $display("FAIL rst_mid_reach got timeout exp valid"); end
    rst_n = 1'b0;
    set_word(0, 10'h022, 1'b1);
    req_valid = 4'b0101;
    @(negedge clk);
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %0b exp 0", tx_data_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %0b exp 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_mid_gid got %0d exp 0", grant_id); end
    n_cmp++; if (tx_data !== 10'h0) begin n_bad++; $display("FAIL rst_mid_data got %h exp 000", tx_data); end
    n_cmp++; if (req_ack !== 4'b0) begin n_bad++; $display("FAIL rst_mid_ack got %b exp 0000", req_ack); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_prio got gid %0d busy %0b exp gid 0 busy 1", grant_id, busy); end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    n_cmp++; if (acc_data.size() != 2 || acc_data[1] !== 10'h022) begin n_bad++; $display("FAIL rst_mid_wire got %0d words exp 2 ending 022", acc_data.size()); end
  endtask

  task automatic test_hold();
    int d, viol = 0;
    do_reset();
    set_word(0, 10'h101, 1'b0);
    set_word(1, 10'h111, 1'b1);
    req_valid = 4'b0011;
    @(negedge clk);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (acc_data.size() == 1 && !tx_data_valid) break;
    end
`ifdef UART_ARB_HOLD_TIMEOUT_EN
    for (d = 0; d < 60 && !timeout_err; d++) begin
      if (grant_id != 2'd0) viol++;
      @(negedge clk);
    end
    n_cmp++; if (d != 16) begin n_bad++; $display("FAIL to_cycles got %0d exp 16", d); end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL to_lock got %0d exp 0", viol); end
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse got %0b exp 0", timeout_err); end
    n_cmp++; if (grant_id !== 2'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL to_regrant got gid %0d busy %0b exp gid 1 busy 1", grant_id, busy); end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    n_cmp++; if (acc_data.size() != 2 || acc_data[1] !== 10'h111) begin n_bad++; $display("FAIL to_wire got %0d words exp 2 ending 111", acc_data.size()); end
`else
    for (d = 0; d < 40; d++) begin
      if (timeout_err !== 1'b0 || grant_id != 2'd0 || busy !== 1'b1) viol++;
      @(negedge clk);
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL hold_lock got %0d bad cycles exp 0", viol); end
    set_word(0, 10'h102, 1'b1);
    req_valid[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ack !== 4'b0001) begin n_bad++; $display("FAIL hold_resume got %b exp 0001", req_ack); end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    n_cmp++; if (acc_data.size() != 2 || acc_data[1] !== 10'h102) begin n_bad++; $display("FAIL hold_wire got %0d words exp 2 ending 102", acc_data.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_packet_lock();
    test_retraction();
    test_reset_mid_send();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter (BITS-wide words, valid/ack/ready handshake) between NREQ requesters, e.g. a slow-control responder, a status reporter and a debug dumper.
- Uses round-robin arbitration with packet locking: a requester keeps the grant until it hands over a word flagged last.
- Sits between the requester blocks and the uart wrapper's tx port, and owns tx_data and tx_data_valid.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BITS, 10, word width; must match the uart BITS.
- GID_W, $clog2(NREQ), width of grant_id.
- HOLD_TIMEOUT, 65535, cycles a locked grant may sit idle (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester word available.
- req_data  in  NREQ*BITS  requester i's word is in slice [i*BITS +: BITS].
- req_last  in  NREQ  word is the last of its packet.
- req_ack  out  NREQ  one-cycle pulse: word taken, requester may advance.
- tx_data  out  BITS  word to uart_tx.
- tx_data_valid  out  1  word presented to uart_tx.
- tx_data_ack  in  1  uart_tx accepted the word (pulse, one cycle after acceptance).
- tx_ready  in  1  uart_tx idle.
- grant_id  out  GID_W  current or most recent grantee.
- busy  out  1  a grant is held (state != IDLE).
- timeout_err  out  1  one-cycle pulse when a lock is broken (optional feature only; otherwise tied 0).

Behaviour:
- Reset (rst_n low at a clock edge), taking priority over everything:
  - state goes to IDLE.
  - req_ack, tx_data_valid, busy and timeout_err go to 0.
  - tx_data and grant_id go to 0.
  - The rr pointer goes to NREQ-1, so requester 0 wins first.
  - Reset mid-SEND drops tx_data_valid the next cycle. uart_tx is reset by the same domain and restarts idle.
- State machine: IDLE, LOAD, SEND, HOLD.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from ptr+1 upward with wrap.
  - Register the pick as grant_id and go to LOAD. busy goes to 1 on the same edge.
- LOAD (1 cycle):
  - If req_valid[grant] = 1: req_ack[grant] = 1 (combinational from state); latch req_data slice into tx_data and req_last into last_q; go to SEND.
  - If req_valid[grant] = 0 (retraction): no ack; return to IDLE if the packet is not yet started, else go to HOLD.
- SEND:
  - tx_data_valid = 1 and tx_data is stable.
  - Wait for tx_data_ack. tx_ready is not used to gate valid, because uart_tx samples valid only while ready.
  - On ack with last_q = 1: ptr <= grant, go to IDLE.
  - On ack with last_q = 0: go to HOLD.
  - tx_data_valid drops the cycle after ack, so no duplicate transfer is possible.
- HOLD:
  - The grant stays locked and other requesters are ignored.
  - When req_valid[grant] = 1, go to LOAD.
- Latency: from req_valid rising in IDLE, req_ack is 1 cycle later and tx_data_valid is 2 cycles later. Back-to-back words within a packet take one uart frame plus 3 cycles each.
- Simultaneous requests resolve purely by the rr pointer. A requester that just finished a packet has the lowest priority next round.
- The word reaching the wire is exactly the latched one; changes on req_data after req_ack have no effect.
- Words with req_valid set but not granted are never acked.

Optional Feature:
- Macro: UART_ARB_HOLD_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to HOLD and increments each HOLD cycle.
  - When it reaches HOLD_TIMEOUT, go to IDLE, set ptr <= grant and pulse timeout_err for 1 cycle.
- When not defined: no counter; HOLD waits indefinitely and timeout_err is constant 0.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE=2'b00, LOAD=2'b01, SEND=2'b10, HOLD=2'b11);
  - default NREQ/BITS constants;
  - the timeout counter width.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: index, any.
  - Reused by future shared-resource controllers.

Test Plan:
- Single word: after reset, req_valid=0001, data=10'h155, last=1. Expect req_ack[0] 1 cycle later, tx_data=10'h155 with valid 2 cycles later, valid low after ack, back to IDLE, busy=0.
- Fairness: all four requesters held valid, single-word packets. Grants go 0,1,2,3,0,… and each requester receives exactly 1 ack per round.
- Packet lock: req1 sends 3 words (last on the third) while req2 is valid throughout. No grant_id=2 appears until req1's third ack; then grant moves to 2.
- Retraction: req3 drops valid in the LOAD cycle. No req_ack, no tx_data_valid, and the arbiter re-arbitrates from IDLE.
- Reset mid-SEND: rst_n low for 1 cycle while tx_data_valid=1. All outputs 0 next cycle, and requester 0 has priority afterwards.
- Timeout (macro on, HOLD_TIMEOUT=16): req0 sends a non-last word, then idles. After 16 HOLD cycles, timeout_err pulses once and waiting req1 is granted.
